// File: rtl/sequential_divider_if.sv
// -----------------------------------------------------------------------------
// sequential_divider_if
// Handshake and operand/result bundle between the ALU control (master) and the
// sequential divider (slave).
//   iStart      master -> slave  request a division
//   iDividend   master -> slave  unsigned dividend, sampled with iStart
//   iDivisor    master -> slave  unsigned divisor, sampled with iStart
//   oBusy       slave  -> master high while the divider iterates
//   oDone       slave  -> master one-cycle completion pulse
//   oQuotient   slave  -> master registered quotient
//   oRemainder  slave  -> master registered remainder
//   oDivByZero  slave  -> master registered divide-by-zero flag
// -----------------------------------------------------------------------------
interface sequential_divider_if #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 4
);
    logic                      iStart;
    logic [DIVIDEND_WIDTH-1:0] iDividend;
    logic [DIVISOR_WIDTH-1:0]  iDivisor;
    logic                      oBusy;
    logic                      oDone;
    logic [DIVIDEND_WIDTH-1:0] oQuotient;
    logic [DIVISOR_WIDTH-1:0]  oRemainder;
    logic                      oDivByZero;

    modport master (
        output iStart,
        output iDividend,
        output iDivisor,
        input  oBusy,
        input  oDone,
        input  oQuotient,
        input  oRemainder,
        input  oDivByZero
    );

    modport slave (
        input  iStart,
        input  iDividend,
        input  iDivisor,
        output oBusy,
        output oDone,
        output oQuotient,
        output oRemainder,
        output oDivByZero
    );
endinterface

// File: rtl/sequential_divider.sv
// -----------------------------------------------------------------------------
// sequential_divider
// Unsigned restoring divider, one quotient bit per clock. Divides a
// DIVIDEND_WIDTH-bit dividend by a DIVISOR_WIDTH-bit divisor. A nonzero
// division keeps oBusy high for DIVIDEND_WIDTH cycles and then pulses oDone for
// one cycle; a zero divisor completes in the cycle after acceptance with
// all-ones results and oDivByZero set. A new request is accepted in IDLE or in
// the DONE cycle, so divisions can run back to back.
// Ports:
//   Clock   single clock, rising-edge
//   Reset   synchronous, active-high; aborts any division without oDone
//   divBus  slave side of sequential_divider_if (start/operands/results)
// -----------------------------------------------------------------------------
module sequential_divider #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 4
) (
    input logic                  Clock,
    input logic                  Reset,
    sequential_divider_if.slave  divBus
);

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    stateR;
    state_t                    stateNext;

    logic [CNT_W-1:0]          countR;
    logic [CNT_W-1:0]          countNext;
    logic [DIVIDEND_WIDTH-1:0] qShiftR;
    logic [DIVIDEND_WIDTH-1:0] qShiftNext;
    // The restoring step always leaves P below the divisor, so the top bit of
    // the (DIVISOR_WIDTH+1)-bit partial remainder is never set and is not kept.
    logic [DIVISOR_WIDTH-1:0]  partialR;
    logic [DIVISOR_WIDTH-1:0]  partialNext;
    logic [DIVISOR_WIDTH-1:0]  divisorR;
    logic [DIVISOR_WIDTH-1:0]  divisorNext;

    logic [DIVIDEND_WIDTH-1:0] quotientR;
    logic [DIVIDEND_WIDTH-1:0] quotientNext;
    logic [DIVISOR_WIDTH-1:0]  remainderR;
    logic [DIVISOR_WIDTH-1:0]  remainderNext;
    logic                      divByZeroR;
    logic                      divByZeroNext;
    logic                      busyR;
    logic                      doneR;

    // One restoring iteration: trial = {P, next dividend bit}.
    logic [DIVISOR_WIDTH:0]    trialS;
    logic                      fitsS;
    logic [DIVISOR_WIDTH-1:0]  stepRemS;
    logic [DIVIDEND_WIDTH-1:0] stepQuotS;
    logic                      zeroDivisorS;

    assign trialS       = {partialR, qShiftR[DIVIDEND_WIDTH-1]};
    assign fitsS        = (trialS >= {1'b0, divisorR});
    // When the divisor fits, trial - divisor < divisor, so modular subtraction
    // on the low DIVISOR_WIDTH bits gives the exact result.
    assign stepRemS     = fitsS ? (trialS[DIVISOR_WIDTH-1:0] - divisorR)
                                : trialS[DIVISOR_WIDTH-1:0];
    assign stepQuotS    = {qShiftR[DIVIDEND_WIDTH-2:0], fitsS};
    assign zeroDivisorS = (divBus.iDivisor == {DIVISOR_WIDTH{1'b0}});

    // Next-state and next-datapath logic for the IDLE/RUN/DONE controller.
    always_comb begin
        stateNext     = stateR;
        countNext     = countR;
        qShiftNext    = qShiftR;
        partialNext   = partialR;
        divisorNext   = divisorR;
        quotientNext  = quotientR;
        remainderNext = remainderR;
        divByZeroNext = divByZeroR;

        case (stateR)
            IDLE, DONE: begin
                if (divBus.iStart) begin
                    if (zeroDivisorS) begin
                        stateNext     = DONE;
                        quotientNext  = {DIVIDEND_WIDTH{1'b1}};
                        remainderNext = {DIVISOR_WIDTH{1'b1}};
                        divByZeroNext = 1'b1;
                    end else begin
                        stateNext   = RUN;
                        countNext   = CNT_W'(DIVIDEND_WIDTH);
                        qShiftNext  = divBus.iDividend;
                        partialNext = {DIVISOR_WIDTH{1'b0}};
                        divisorNext = divBus.iDivisor;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            RUN: begin
                qShiftNext  = stepQuotS;
                partialNext = stepRemS;
                countNext   = countR - CNT_W'(1);
                if (countR == CNT_W'(1)) begin
                    stateNext     = DONE;
                    quotientNext  = stepQuotS;
                    remainderNext = stepRemS;
                    divByZeroNext = 1'b0;
                end else begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNext;
        end
    end

    // Datapath and registered outputs; busy/done are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            countR     <= {CNT_W{1'b0}};
            qShiftR    <= {DIVIDEND_WIDTH{1'b0}};
            partialR   <= {DIVISOR_WIDTH{1'b0}};
            divisorR   <= {DIVISOR_WIDTH{1'b0}};
            quotientR  <= {DIVIDEND_WIDTH{1'b0}};
            remainderR <= {DIVISOR_WIDTH{1'b0}};
            divByZeroR <= 1'b0;
            busyR      <= 1'b0;
            doneR      <= 1'b0;
        end else begin
            countR     <= countNext;
            qShiftR    <= qShiftNext;
            partialR   <= partialNext;
            divisorR   <= divisorNext;
            quotientR  <= quotientNext;
            remainderR <= remainderNext;
            divByZeroR <= divByZeroNext;
            busyR      <= (stateNext == RUN);
            doneR      <= (stateNext == DONE);
        end
    end

    assign divBus.oBusy      = busyR;
    assign divBus.oDone      = doneR;
    assign divBus.oQuotient  = quotientR;
    assign divBus.oRemainder = remainderR;
    assign divBus.oDivByZero = divByZeroR;

endmodule

// File: tb/tb_sequential_divider.sv
// -----------------------------------------------------------------------------
// tb_sequential_divider
// Directed-vector bench for sequential_divider plus a full operand sweep
// against q = a / b, r = a % b (all-ones and flag for b = 0).
// -----------------------------------------------------------------------------
module tb_sequential_divider;

    logic Clock;
    logic Reset;

    sequential_divider_if #(.DIVIDEND_WIDTH(8), .DIVISOR_WIDTH(4)) divBus ();

    sequential_divider #(
        .DIVIDEND_WIDTH(8),
        .DIVISOR_WIDTH (4)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .divBus(divBus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checkCount  = 0;
    int passCount   = 0;
    int holdErr     = 0;
    int overlapErr  = 0;

    task automatic checkValue(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Called on a falling edge; drives one request, then follows the divider
    // until oDone (bounded), counting busy cycles. Returns on the falling edge
    // of the done cycle so a follow-up request lands in DONE.
    task automatic runDiv(input logic [7:0] a, input logic [3:0] b,
                          input int injectAt, output int lat, output int busyCnt);
        logic [7:0] hq;
        logic [3:0] hr;
        logic       hd;
        hq = divBus.oQuotient;
        hr = divBus.oRemainder;
        hd = divBus.oDivByZero;
        divBus.iStart    = 1'b1;
        divBus.iDividend = a;
        divBus.iDivisor  = b;
        @(posedge Clock);
        @(negedge Clock);
        divBus.iStart = 1'b0;
        lat     = 0;
        busyCnt = 0;
        for (int n = 1; n <= 20; n++) begin
            if (injectAt != 0 && n == injectAt + 1) divBus.iStart = 1'b0;
            if (divBus.oBusy && divBus.oDone) overlapErr++;
            if (divBus.oDone) begin
                lat = n;
                break;
            end
            if (divBus.oBusy) begin
                busyCnt++;
                if ({divBus.oQuotient, divBus.oRemainder, divBus.oDivByZero} !== {hq, hr, hd})
                    holdErr++;
            end
            if (injectAt != 0 && n == injectAt) begin
                divBus.iStart    = 1'b1;
                divBus.iDividend = 8'd50;
                divBus.iDivisor  = 4'd5;
            end
            @(negedge Clock);
        end
    endtask

    task automatic checkResult(input string tag, input logic [7:0] q,
                               input logic [3:0] r, input logic dbz);
        checkValue({tag, " quotient"},  {24'd0, divBus.oQuotient},  {24'd0, q});
        checkValue({tag, " remainder"}, {28'd0, divBus.oRemainder}, {28'd0, r});
        checkValue({tag, " divbyzero"}, {31'd0, divBus.oDivByZero}, {31'd0, dbz});
    endtask

    int lat;
    int busyCnt;
    int doneCnt;
    logic [7:0]  expQ;
    logic [3:0]  expR;
    logic        expZ;
    logic [28:0] gotPack;
    logic [28:0] expPack;

    initial begin
        Reset            = 1'b1;
        divBus.iStart    = 1'b0;
        divBus.iDividend = 8'd0;
        divBus.iDivisor  = 4'd0;
        repeat (3) @(negedge Clock);
        checkValue("reset busy", {31'd0, divBus.oBusy}, 32'd0);
        checkValue("reset done", {31'd0, divBus.oDone}, 32'd0);
        checkResult("reset", 8'd0, 4'd0, 1'b0);
        Reset = 1'b0;
        @(negedge Clock);

        // 200 / 7 = 28 r 4
        runDiv(8'd200, 4'd7, 0, lat, busyCnt);
        checkValue("200/7 latency", lat, 32'd9);
        checkValue("200/7 busy cycles", busyCnt, 32'd8);
        checkResult("200/7", 8'd28, 4'd4, 1'b0);
        @(negedge Clock);
        checkValue("done pulse width", {31'd0, divBus.oDone}, 32'd0);
        checkValue("result held after done", {24'd0, divBus.oQuotient}, 32'd28);

        // 255 / 15 = 17 r 0, then 5 / 9 started in the DONE cycle
        runDiv(8'd255, 4'd15, 0, lat, busyCnt);
        checkResult("255/15", 8'd17, 4'd0, 1'b0);
        runDiv(8'd5, 4'd9, 0, lat, busyCnt);
        checkValue("5/9 back-to-back latency", lat, 32'd9);
        checkResult("5/9", 8'd0, 4'd5, 1'b0);
        @(negedge Clock);

        // 13 / 0, then 12 / 3
        runDiv(8'd13, 4'd0, 0, lat, busyCnt);
        checkValue("13/0 latency", lat, 32'd1);
        checkValue("13/0 busy cycles", busyCnt, 32'd0);
        checkResult("13/0", 8'hFF, 4'hF, 1'b1);
        @(negedge Clock);
        runDiv(8'd12, 4'd3, 0, lat, busyCnt);
        checkResult("12/3", 8'd4, 4'd0, 1'b0);
        @(negedge Clock);

        // 100 / 6 with a 50 / 5 request during RUN cycle 3
        runDiv(8'd100, 4'd6, 3, lat, busyCnt);
        checkValue("100/6 latency", lat, 32'd9);
        checkResult("100/6 ignore start", 8'd16, 4'd4, 1'b0);
        doneCnt = 0;
        repeat (12) begin
            @(negedge Clock);
            if (divBus.oDone) doneCnt++;
        end
        checkValue("no queued request", doneCnt, 32'd0);

        // Reset during RUN cycle 4 of 200 / 7
        divBus.iStart    = 1'b1;
        divBus.iDividend = 8'd200;
        divBus.iDivisor  = 4'd7;
        @(posedge Clock);
        @(negedge Clock);
        divBus.iStart = 1'b0;
        repeat (3) @(negedge Clock);
        checkValue("abort busy before reset", {31'd0, divBus.oBusy}, 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        checkValue("abort busy", {31'd0, divBus.oBusy}, 32'd0);
        checkValue("abort done", {31'd0, divBus.oDone}, 32'd0);
        checkResult("abort", 8'd0, 4'd0, 1'b0);
        Reset = 1'b0;
        doneCnt = 0;
        repeat (12) begin
            @(negedge Clock);
            if (divBus.oDone) doneCnt++;
        end
        checkValue("abort no done", doneCnt, 32'd0);
        runDiv(8'd9, 4'd2, 0, lat, busyCnt);
        checkValue("9/2 latency", lat, 32'd9);
        checkResult("9/2", 8'd4, 4'd1, 1'b0);
        @(negedge Clock);

        // Full sweep, every division restarted from the previous DONE cycle
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                runDiv(8'(a), 4'(b), 0, lat, busyCnt);
                if (b == 0) begin
                    expQ = 8'hFF;
                    expR = 4'hF;
                    expZ = 1'b1;
                    expPack = {8'd1, 8'd0, expQ, expR, expZ};
                end else begin
                    expQ = 8'(a / b);
                    expR = 4'(a % b);
                    expZ = 1'b0;
                    expPack = {8'd9, 8'd8, expQ, expR, expZ};
                end
                gotPack = {8'(lat), 8'(busyCnt), divBus.oQuotient,
                           divBus.oRemainder, divBus.oDivByZero};
                checkValue($sformatf("sweep %0d/%0d {lat,busy,q,r,z}", a, b),
                           {3'd0, gotPack}, {3'd0, expPack});
            end
        end
        @(negedge Clock);
        checkValue("sweep final done width", {31'd0, divBus.oDone}, 32'd0);
        checkValue("outputs stable while busy", holdErr, 32'd0);
        checkValue("busy and done exclusive", overlapErr, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Unsigned multi-cycle divider that inverts the 4-bit array-multiplier datapath: it divides an 8-bit dividend (the width of an IMUL product) by a 4-bit divisor using restoring division, one quotient bit per clock. It sits next to the MiniAlu datapath as the back end of a future IDIV opcode. Operands arrive from the RAM read ports; quotient and remainder go back to the RAM write path. A start/done handshake lets the ALU control stall while the divider runs.

## Interface
- DIVIDEND_WIDTH, 8: dividend and quotient width.
- DIVISOR_WIDTH, 4: divisor and remainder width; must be ≤ DIVIDEND_WIDTH.
- Clock  in  1: single clock; all state updates on the rising edge.
- Reset  in  1: reset is synchronous and active-high.
- iStart  in  1: request a division; sampled only in IDLE or DONE.
- iDividend  in  DIVIDEND_WIDTH: unsigned dividend; sampled with iStart.
- iDivisor  in  DIVISOR_WIDTH: unsigned divisor; sampled with iStart.
- oBusy  out  1: high while in RUN.
- oDone  out  1: one-cycle pulse; results are valid from this cycle on.
- oQuotient  out  DIVIDEND_WIDTH: registered quotient.
- oRemainder  out  DIVISOR_WIDTH: registered remainder.
- oDivByZero  out  1: registered flag; set when the last accepted divisor was 0.

## Operation
- State machine has three states: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: oBusy=0, oDone=0, oQuotient=0, oRemainder=0, oDivByZero=0, iteration counter=0.
- IDLE with iStart=1 and iDivisor≠0:
  - latch the divisor;
  - load the quotient shift register with iDividend;
  - clear the partial remainder P (DIVISOR_WIDTH+1 bits);
  - set counter=DIVIDEND_WIDTH and go to RUN.
- IDLE with iStart=1 and iDivisor=0:
  - go directly to DONE;
  - oQuotient = all ones (8'hFF), oRemainder = all ones (4'hF), oDivByZero=1.
- RUN, each cycle:
  - T = {P[DIVISOR_WIDTH-1:0], Qreg MSB};
  - shift Qreg left by one;
  - if T ≥ divisor: P = T − divisor and Qreg LSB = 1; else P = T and Qreg LSB = 0;
  - decrement counter.
  - When the counter reaches 1 (last iteration), go to DONE and load oQuotient and oRemainder from the post-iteration values. oDivByZero=0.
- P never exceeds DIVISOR_WIDTH+1 bits. The final remainder is always < divisor and fits in DIVISOR_WIDTH bits.
- DONE lasts exactly one cycle (oDone=1), then returns to IDLE.
  - iStart=1 in DONE is accepted exactly as in IDLE, so back-to-back divisions are possible.
- iStart in RUN is ignored and not queued. Operand inputs are don't-care outside the accepting cycle.
- oQuotient, oRemainder and oDivByZero hold their values until the next completion or Reset. They do not change during RUN.
- Reset asserted in any state, including mid-RUN:
  - next edge goes to IDLE and all outputs return to their reset values;
  - the in-progress division is discarded with no oDone pulse.

## Timing
- Accept edge E: iStart sampled high in IDLE or DONE.
- Nonzero divisor: oBusy=1 for DIVIDEND_WIDTH cycles (8). oDone=1 and results valid in the cycle after edge E+8. Start-to-done latency is 9 cycles counting the accept cycle.
- Zero divisor: oDone=1 in the cycle after edge E, with oBusy never asserted.
- oBusy and oDone are never high simultaneously.
- All outputs are registered; no combinational path from inputs to outputs.
- Maximum throughput: one division per 9 cycles, restarting from DONE.

## Test plan
- Reset then 200/7 → after 8 busy cycles, oDone pulse with oQuotient=28, oRemainder=4, oDivByZero=0.
- 255/15 → oQuotient=17, oRemainder=0. Then 5/9, started in the DONE cycle → oQuotient=0, oRemainder=5 exactly 9 cycles later.
- 13/0 → oDone in the cycle after acceptance, oQuotient=8'hFF, oRemainder=4'hF, oDivByZero=1, oBusy never high. A following 12/3 → oQuotient=4, oRemainder=0, oDivByZero=0.
- Start 100/6, pulse iStart with 50/5 during RUN cycle 3 → the second request is ignored; result oQuotient=16, oRemainder=4; no second oDone.
- Start 200/7, assert Reset on RUN cycle 4 → next cycle IDLE, all outputs 0, no oDone. A subsequent 9/2 → oQuotient=4, oRemainder=1.
- Exhaustive sweep of all 256×16 operand pairs against a reference model (q=a/b, r=a%b; b=0 handled per rules). Also check oDone width is exactly 1 cycle and outputs are stable between completions.
